// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory responder with byte/halfword/word loads and stores.
// Latency: response pulse LATENCY cycles after the accept cycle; one request per LATENCY+1 cycles.
// Backpressure: req_ready is low from accept until the cycle after the response; no response backpressure.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // WAIT lasts LATENCY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] mem [DEPTH_WORDS];

    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        accept;
    logic        enter_resp;
    logic        src_write;
    logic [2:0]  src_funct3;
    logic [31:0] src_addr;
    logic        src_err;
    logic        cap_err;
    logic [31:0] rd_word;
    logic [3:0]  be;
    logic [31:0] wlanes;

    // Flags illegal funct3, misalignment and out-of-range word index.
    function automatic logic bad_req(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        if (wr) begin
            if (!(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) bad = 1'b1;
        end else begin
            if (!(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                  f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
        end
        if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
        if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
        return bad;
    endfunction

    // Selects the addressed lane and applies sign or zero extension.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the response is formed on the accept edge itself, so the
    // live request fields are used in IDLE and the captured copy otherwise.
    assign src_write  = (state == IDLE) ? req_write  : cap_write;
    assign src_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
    assign src_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign src_err    = bad_req(src_write, src_funct3, src_addr);
    assign cap_err    = bad_req(cap_write, cap_funct3, cap_addr);
    assign rd_word    = mem[src_addr[AW+1:2]];
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign rsp_valid  = (state == RESP);

    // Next-state, countdown and ready decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request capture; fields are held until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
        end
    end

    // Registered response payload, zero outside the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= src_err;
            rsp_rdata <= (src_err || src_write) ? 32'h0
                                                : load_ext(src_funct3, src_addr[1:0], rd_word);
        end else begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be     = 4'b0000;
        wlanes = cap_wdata;
        case (cap_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << cap_addr[1:0];
                wlanes = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                be     = cap_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cap_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Store commit on the edge ending RESP; a reset on that edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && cap_write && !cap_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[cap_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 4 and 1.
// Each transaction checks response timing, ready pattern and payload.
// Expected values are hand-computed constants.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        vld [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter for accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request on instance s; checks timing over the LATENCY window and the idle cycle after.
    task automatic txn(input int s, input int lat, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        wr = w; f3 = fn; addr = a; wdata = d; vld[s] = 1'b1;
        n = 0;
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[s]) begin
            chk({tag, " ready_timeout"}, 32'(rdy[s]), 32'd1);
            vld[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 vld[s] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({tag, " rsp_valid"}, 32'(rv[s]), 32'(k == lat));
            chk({tag, " req_ready_busy"}, 32'(rdy[s]), 32'd0);
            if (k == lat) begin
                chk({tag, " rdata"}, rd[s], exp_data);
                chk({tag, " err"}, 32'(er[s]), 32'(exp_err));
            end
        end
        @(negedge clk);
        chk({tag, " rsp_valid_end"}, 32'(rv[s]), 32'd0);
        chk({tag, " req_ready_end"}, 32'(rdy[s]), 32'd1);
        chk({tag, " rdata_idle"}, rd[s], 32'd0);
    endtask

    initial begin
        logic [31:0] exp_w [3];
        int          acc [3];
        int          n;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            vld[i] = 1'b0;
        end
        wr = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;

        // Reset: ready held low while rst is high, then clean idle values.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ready_in_reset", 32'(rdy[i]), 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(rdy[i]), 32'd1);
            chk("reset_rsp_valid", 32'(rv[i]), 32'd0);
            chk("reset_rdata", rd[i], 32'd0);
            chk("reset_err", 32'(er[i]), 32'd0);
        end

        // LATENCY=2: word store/load.
        txn(0, 2, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        txn(0, 2, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");

        // Byte store into lane 3, then word/byte loads.
        txn(0, 2, 1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0, "sw_20");
        txn(0, 2, 1'b1, 3'b000, 32'h23, 32'h12345680, 32'h0, 1'b0, "sb_23");
        txn(0, 2, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80000000, 1'b0, "lw_20");
        txn(0, 2, 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, "lb_23");
        txn(0, 2, 1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0, "lbu_23");

        // Halfword loads with sign and zero extension.
        txn(0, 2, 1'b1, 3'b010, 32'h30, 32'h80017FFF, 32'h0, 1'b0, "sw_30");
        txn(0, 2, 1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, "lh_32");
        txn(0, 2, 1'b0, 3'b101, 32'h32, 32'h0, 32'h00008001, 1'b0, "lhu_32");
        txn(0, 2, 1'b0, 3'b001, 32'h30, 32'h0, 32'h00007FFF, 1'b0, "lh_30");

        // Error requests.
        txn(0, 2, 1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, "lw_misaligned");
        txn(0, 2, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, "sw_40");
        txn(0, 2, 1'b1, 3'b001, 32'h41, 32'h00005555, 32'h0, 1'b1, "sh_misaligned");
        txn(0, 2, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, "lw_40_unchanged");
        txn(0, 2, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, "load_f3_011");
        txn(0, 2, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
        txn(0, 2, 1'b1, 3'b010, 32'h3FC, 32'h5A5AA5A5, 32'h0, 1'b0, "sw_last");
        txn(0, 2, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h5A5AA5A5, 1'b0, "lw_last");

        // LATENCY=4: reset in the 2nd WAIT cycle aborts a store.
        txn(1, 4, 1'b1, 3'b010, 32'h50, 32'h22222222, 32'h0, 1'b0, "l4_sw_prior");
        @(negedge clk);
        wr = 1'b1; f3 = 3'b010; addr = 32'h50; wdata = 32'h11111111; vld[1] = 1'b1;
        chk("l4_ready_before", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(posedge clk);
        #1 rst[1] = 1'b1;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("l4_abort_no_rsp", 32'(rv[1]), 32'd0);
            chk("l4_abort_ready", 32'(rdy[1]), 32'd1);
        end
        txn(1, 4, 1'b0, 3'b010, 32'h50, 32'h0, 32'h22222222, 1'b0, "l4_lw_after_abort");

        // LATENCY=1: preload, then three back-to-back loads with req_valid held high.
        exp_w[0] = 32'hA1A1A1A1;
        exp_w[1] = 32'hB2B2B2B2;
        exp_w[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++)
            txn(2, 1, 1'b1, 3'b010, 32'h60 + 32'(4 * i), exp_w[i], 32'h0, 1'b0, "l1_preload");
        @(negedge clk);
        wr = 1'b0; f3 = 3'b010; addr = 32'h60; vld[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!rdy[2] && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready", 32'(rdy[2]), 32'd1);
            @(posedge clk);
            #1 acc[i] = cyc;
            if (i < 2) addr = 32'h64 + 32'(4 * i);
            else       vld[2] = 1'b0;
            @(negedge clk);
            chk("b2b_rsp_valid", 32'(rv[2]), 32'd1);
            chk("b2b_rdata", rd[2], exp_w[i]);
            chk("b2b_busy", 32'(rdy[2]), 32'd0);
            @(negedge clk);
            chk("b2b_rsp_fall", 32'(rv[2]), 32'd0);
            if (i > 0) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
